// File: rtl/msrv32_dbus_arbiter_if.sv
// Requester-side and AHB-lite data-bus signals of the data-bus arbiter.
// The arbiter connects through the master modport; the environment uses slave.
interface msrv32_dbus_arbiter_if;
  logic        core_req_in;
  logic        aux_req_in;
  logic        core_wr_in;
  logic        aux_wr_in;
  logic [31:0] core_addr_in;
  logic [31:0] aux_addr_in;
  logic [31:0] core_wdata_in;
  logic [31:0] aux_wdata_in;
  logic [3:0]  core_mask_in;
  logic [3:0]  aux_mask_in;
  logic        core_gnt_out;
  logic        aux_gnt_out;
  logic        core_done_out;
  logic        aux_done_out;
  logic [31:0] rdata_out;
  logic        err_out;
  logic [31:0] ms_riscv32_mp_dmaddr_out;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
  logic        ms_riscv32_mp_dmwr_req_out;
  logic [31:0] ms_riscv32_mp_dmdata_out;
  logic [1:0]  ahb_htrans_out;
  logic [31:0] ms_riscv32_mp_dmdata_in;
  logic        ahb_ready_in;
  logic        ahb_resp_in;

  modport master (
    input  core_req_in, aux_req_in, core_wr_in, aux_wr_in,
    input  core_addr_in, aux_addr_in, core_wdata_in, aux_wdata_in,
    input  core_mask_in, aux_mask_in,
    input  ms_riscv32_mp_dmdata_in, ahb_ready_in, ahb_resp_in,
    output core_gnt_out, aux_gnt_out, core_done_out, aux_done_out,
    output rdata_out, err_out,
    output ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmwr_mask_out,
    output ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmdata_out, ahb_htrans_out
  );

  modport slave (
    output core_req_in, aux_req_in, core_wr_in, aux_wr_in,
    output core_addr_in, aux_addr_in, core_wdata_in, aux_wdata_in,
    output core_mask_in, aux_mask_in,
    output ms_riscv32_mp_dmdata_in, ahb_ready_in, ahb_resp_in,
    input  core_gnt_out, aux_gnt_out, core_done_out, aux_done_out,
    input  rdata_out, err_out,
    input  ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmwr_mask_out,
    input  ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmdata_out, ahb_htrans_out
  );
endinterface

// File: rtl/msrv32_dbus_arbiter.sv
// Core/aux arbiter for the single AHB-lite data port: IDLE -> ADDR -> DATA.
// Optional data-phase timeout enabled by defining DBUS_TIMEOUT_EN.
module msrv32_dbus_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  msrv32_dbus_arbiter_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_aux_q, owner_aux_d;
  logic [3:0]  starve_q, starve_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        pick_aux;
  logic        timeout;

`ifdef DBUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_ADDR) begin
      to_cnt_d = '0;
    end else if (state_q == S_DATA && !bus.ahb_ready_in) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  // Fires in the last tolerated ready-low data cycle; a later HREADY is never seen.
  assign timeout = (state_q == S_DATA) && !bus.ahb_ready_in && (to_cnt_q == TO_LAST);

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  assign pick_aux = bus.aux_req_in && (!bus.core_req_in || starve_q == STARVE_MAX);

  always_comb begin
    state_d     = state_q;
    owner_aux_d = owner_aux_q;
    starve_d    = starve_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;

    bus.core_gnt_out                = 1'b0;
    bus.aux_gnt_out                 = 1'b0;
    bus.core_done_out               = 1'b0;
    bus.aux_done_out                = 1'b0;
    bus.rdata_out                   = '0;
    bus.err_out                     = 1'b0;
    bus.ms_riscv32_mp_dmaddr_out    = '0;
    bus.ms_riscv32_mp_dmwr_mask_out = '0;
    bus.ms_riscv32_mp_dmwr_req_out  = 1'b0;
    bus.ms_riscv32_mp_dmdata_out    = '0;
    bus.ahb_htrans_out              = 2'b00;

    if (!bus.aux_req_in) begin
      starve_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.core_req_in || bus.aux_req_in) begin
          state_d     = S_ADDR;
          owner_aux_d = pick_aux;
          wr_d        = pick_aux ? bus.aux_wr_in    : bus.core_wr_in;
          addr_d      = pick_aux ? bus.aux_addr_in  : bus.core_addr_in;
          wdata_d     = pick_aux ? bus.aux_wdata_in : bus.core_wdata_in;
          mask_d      = pick_aux ? bus.aux_mask_in  : bus.core_mask_in;
          // Count only core wins that made a waiting aux master lose.
          if (pick_aux) begin
            starve_d = '0;
          end else if (bus.aux_req_in && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      S_ADDR: begin
        bus.ahb_htrans_out              = 2'b10;
        bus.ms_riscv32_mp_dmaddr_out    = addr_q;
        bus.ms_riscv32_mp_dmwr_mask_out = mask_q;
        bus.ms_riscv32_mp_dmwr_req_out  = wr_q;
        bus.core_gnt_out                = !owner_aux_q;
        bus.aux_gnt_out                 = owner_aux_q;
        state_d                         = S_DATA;
      end
      S_DATA: begin
        bus.ms_riscv32_mp_dmdata_out = wdata_q;
        if (bus.ahb_ready_in || timeout) begin
          bus.core_done_out = !owner_aux_q;
          bus.aux_done_out  = owner_aux_q;
          bus.rdata_out     = (bus.ahb_ready_in && !wr_q) ? bus.ms_riscv32_mp_dmdata_in : '0;
          bus.err_out       = timeout ? 1'b1 : bus.ahb_resp_in;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q     <= S_IDLE;
      owner_aux_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_aux_q <= owner_aux_d;
      starve_q    <= starve_d;
    end
  end

  // Payload is only observed through state-gated outputs, so it needs no reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
  end
endmodule

// File: tb/tb_msrv32_dbus_arbiter.sv
// Directed bench for msrv32_dbus_arbiter with a per-cycle transaction model.
// Covers DBUS_TIMEOUT_EN both defined and undefined.
module tb_msrv32_dbus_arbiter;
  localparam int SL = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  msrv32_dbus_arbiter_if bus();

  msrv32_dbus_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: age = -1 no access, 0 address phase, k>=1 the k-th data-phase cycle.
  int          age;
  int          streak;
  bit          own_aux;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_mask;

  bit          e_to, e_fin, e_pick_aux;
  logic [31:0] e_rdata, e_addr, e_dmdata;

  always_comb begin
    e_to = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    e_to = (age == TO) && !bus.ahb_ready_in;
`endif
    e_fin      = (age >= 1) && (bus.ahb_ready_in || e_to);
    e_pick_aux = bus.aux_req_in && (!bus.core_req_in || streak >= SL);
    e_rdata    = (e_fin && !e_to && !m_wr) ? bus.ms_riscv32_mp_dmdata_in : 32'h0;
    e_addr     = (age == 0) ? m_addr : 32'h0;
    e_dmdata   = (age >= 1) ? m_wdata : 32'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age    <= -1;
      streak <= 0;
    end else begin
      if (!bus.aux_req_in) streak <= 0;
      if (age < 0) begin
        if (bus.core_req_in || bus.aux_req_in) begin
          own_aux <= e_pick_aux;
          m_wr    <= e_pick_aux ? bus.aux_wr_in    : bus.core_wr_in;
          m_addr  <= e_pick_aux ? bus.aux_addr_in  : bus.core_addr_in;
          m_wdata <= e_pick_aux ? bus.aux_wdata_in : bus.core_wdata_in;
          m_mask  <= e_pick_aux ? bus.aux_mask_in  : bus.core_mask_in;
          age     <= 0;
          if (e_pick_aux) streak <= 0;
          else if (bus.aux_req_in) streak <= (streak + 1 > SL) ? SL : streak + 1;
        end
      end else if (age == 0) begin
        age <= 1;
      end else if (e_fin) begin
        age <= -1;
      end else begin
        age <= age + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("core_gnt",  32'(bus.core_gnt_out),  32'(age == 0 && !own_aux));
    check("aux_gnt",   32'(bus.aux_gnt_out),   32'(age == 0 && own_aux));
    check("core_done", 32'(bus.core_done_out), 32'(e_fin && !own_aux));
    check("aux_done",  32'(bus.aux_done_out),  32'(e_fin && own_aux));
    check("htrans",    32'(bus.ahb_htrans_out), (age == 0) ? 32'd2 : 32'd0);
    check("dmaddr",    bus.ms_riscv32_mp_dmaddr_out, e_addr);
    check("mask",      32'(bus.ms_riscv32_mp_dmwr_mask_out), (age == 0) ? 32'(m_mask) : 32'h0);
    check("wr_req",    32'(bus.ms_riscv32_mp_dmwr_req_out), 32'(age == 0 && m_wr));
    check("dmdata",    bus.ms_riscv32_mp_dmdata_out, e_dmdata);
    check("rdata",     bus.rdata_out, e_rdata);
    check("err",       32'(bus.err_out), 32'(e_fin && (e_to || bus.ahb_resp_in)));
  end

  task automatic core_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.core_req_in = 1'b1; bus.core_wr_in = wr; bus.core_addr_in = a;
    bus.core_wdata_in = d; bus.core_mask_in = m;
  endtask

  task automatic aux_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.aux_req_in = 1'b1; bus.aux_wr_in = wr; bus.aux_addr_in = a;
    bus.aux_wdata_in = d; bus.aux_mask_in = m;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  int order[$];
  int exp_order[6] = '{1, 1, 2, 1, 1, 2};
  int dn;

  initial begin
    bus.core_req_in = 0; bus.core_wr_in = 0; bus.core_addr_in = 0; bus.core_wdata_in = 0; bus.core_mask_in = 0;
    bus.aux_req_in  = 0; bus.aux_wr_in  = 0; bus.aux_addr_in  = 0; bus.aux_wdata_in  = 0; bus.aux_mask_in  = 0;
    bus.ms_riscv32_mp_dmdata_in = 0; bus.ahb_ready_in = 1; bus.ahb_resp_in = 0;

    @(negedge clk);
    check("rst_htrans", 32'(bus.ahb_htrans_out), 32'd0);
    check("rst_done",   32'(bus.core_done_out | bus.aux_done_out), 32'd0);
    next_cycle(); rst = 0;
    next_cycle();

    // Core write, zero-wait
    core_req(1'b1, 32'h0000_1000, 32'hDEADBEEF, 4'hF);
    @(negedge clk); check("t1_gnt_n", 32'(bus.core_gnt_out), 32'd0);
    @(negedge clk);
    check("t1_htrans", 32'(bus.ahb_htrans_out), 32'd2);
    check("t1_addr",   bus.ms_riscv32_mp_dmaddr_out, 32'h0000_1000);
    check("t1_wr",     32'(bus.ms_riscv32_mp_dmwr_req_out), 32'd1);
    check("t1_gnt",    32'(bus.core_gnt_out), 32'd1);
    @(negedge clk);
    check("t1_dmdata", bus.ms_riscv32_mp_dmdata_out, 32'hDEADBEEF);
    check("t1_done",   32'(bus.core_done_out), 32'd1);
    next_cycle(); bus.core_req_in = 0;
    next_cycle();

    // Both requesting back-to-back
    core_req(1'b1, 32'h0000_0100, 32'h1111_1111, 4'h3);
    aux_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    bus.ms_riscv32_mp_dmdata_in = 32'hA5A5_0001;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      @(negedge clk);
      if (bus.core_gnt_out) order.push_back(1);
      if (bus.aux_gnt_out)  order.push_back(2);
    end
    @(negedge clk);
    next_cycle(); bus.core_req_in = 0; bus.aux_req_in = 0;
    check("t2_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd0, 32'(exp_order[i]));
    end
    next_cycle();

    // Aux read with three wait states
    bus.ahb_ready_in = 0; bus.ms_riscv32_mp_dmdata_in = 32'h12345678;
    aux_req(1'b0, 32'h0000_2004, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("t3_gnt",  32'(bus.aux_gnt_out), 32'd1);
    check("t3_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0000_2004);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); check($sformatf("t3_wait%0d", k), 32'(bus.aux_done_out), 32'd0);
    end
    next_cycle(); bus.ahb_ready_in = 1;
    @(negedge clk);
    check("t3_done",  32'(bus.aux_done_out), 32'd1);
    check("t3_rdata", bus.rdata_out, 32'h12345678);
    check("t3_cdone", 32'(bus.core_done_out), 32'd0);
    next_cycle(); bus.aux_req_in = 0;
    next_cycle();

    // Core read with error response
    bus.ahb_resp_in = 1; bus.ms_riscv32_mp_dmdata_in = 32'hCAFE_0000;
    core_req(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("t4_done",  32'(bus.core_done_out), 32'd1);
    check("t4_err",   32'(bus.err_out), 32'd1);
    check("t4_rdata", bus.rdata_out, 32'hCAFE_0000);
    next_cycle(); bus.core_req_in = 0; bus.ahb_resp_in = 0;
    next_cycle();

    // Reset in the data phase
    bus.ahb_ready_in = 0;
    core_req(1'b1, 32'h0000_5000, 32'h5555_AAAA, 4'hF);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 rst = 1;
    #1;
    check("t5_htrans", 32'(bus.ahb_htrans_out), 32'd0);
    check("t5_gnt",    32'(bus.core_gnt_out), 32'd0);
    check("t5_done",   32'(bus.core_done_out), 32'd0);
    check("t5_dmdata", bus.ms_riscv32_mp_dmdata_out, 32'h0);
    bus.core_req_in = 0; bus.ahb_ready_in = 1;
    next_cycle(); rst = 0;
    dn = 0;
    repeat (3) begin
      @(negedge clk); if (bus.core_done_out || bus.aux_done_out) dn++;
    end
    check("t5_no_done", 32'(dn), 32'd0);
    next_cycle();
    core_req(1'b1, 32'h0000_6000, 32'h0606_0606, 4'h1);
    @(negedge clk); @(negedge clk);
    check("t5_regnt", 32'(bus.core_gnt_out), 32'd1);
    @(negedge clk);
    check("t5_redone", 32'(bus.core_done_out), 32'd1);
    next_cycle(); bus.core_req_in = 0;
    next_cycle();

    // Data phase that never sees HREADY
    bus.ahb_ready_in = 0; bus.ms_riscv32_mp_dmdata_in = 32'hFFFF_FFFF;
    core_req(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
`ifdef DBUS_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check($sformatf("t6_done%0d", k), 32'(bus.core_done_out), 32'(k == TO));
      if (k == TO) begin
        check("t6_err",   32'(bus.err_out), 32'd1);
        check("t6_rdata", bus.rdata_out, 32'h0);
      end
    end
    next_cycle(); bus.core_req_in = 0; bus.ahb_ready_in = 1;
    repeat (3) next_cycle();
`else
    dn = 0;
    repeat (100) begin
      @(negedge clk); if (bus.core_done_out) dn++;
    end
    check("t6_no_done", 32'(dn), 32'd0);
    next_cycle(); bus.ahb_ready_in = 1;
    @(negedge clk);
    check("t6_done",  32'(bus.core_done_out), 32'd1);
    check("t6_rdata", bus.rdata_out, 32'hFFFF_FFFF);
    next_cycle(); bus.core_req_in = 0;
    repeat (3) next_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
